module_keypad_emulator: RTL and testbench

- Synthesizable model of a passive 4x4 membrane keypad.
- The keypad scanner drives the row lines; this block answers on the column lines with the bouncing contact behaviour of a real key press.
- Used as the far end of the keypad interface for board self-test and benches. A valid/ready command port "types" one key per transaction.

---
 rtl/module_keypad_emulator.sv | 161 ++++++++++++++++
 tb/tb_module_keypad_emulator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_keypad_emulator.sv
// rtl/module_keypad_emulator.sv - passive 4x4 membrane keypad answering the row scan with bouncing key presses
module module_keypad_emulator #(
    parameter int BOUNCE_CYCLES = 5,
    parameter int PRESS_CYCLES  = 200,
    parameter int GAP_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic       abort,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic       contact,
    output logic       busy,
    output logic       done
);

    localparam int MAX_BP = (BOUNCE_CYCLES > PRESS_CYCLES) ? BOUNCE_CYCLES : PRESS_CYCLES;
    localparam int MAX_N  = (MAX_BP > GAP_CYCLES) ? MAX_BP : GAP_CYCLES;
    localparam int CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CW-1:0] BNC_LOAD   = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] PRESS_LOAD = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, BNC_DN, HOLD, BNC_UP, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [3:0]      code_q, code_d;
    logic            done_q, done_d;
    logic            cnt_last;
    logic [1:0]      key_row, key_col;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        done_d   = 1'b0;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cnt_last = (cnt_q == '0);
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    code_d = key_code;
                    if (BOUNCE_CYCLES > 0) begin
                        state_d = BNC_DN;
                        cnt_d   = BNC_LOAD;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = PRESS_LOAD;
                    end
                end
            end
            BNC_DN: begin
                if (cnt_last) begin
                    state_d = HOLD;
                    cnt_d   = PRESS_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    if (BOUNCE_CYCLES > 0) begin
                        state_d = BNC_UP;
                        cnt_d   = BNC_LOAD;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            BNC_UP: begin
                if (cnt_last) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // abort overrides the natural exit of any phase with the contact possibly closed
        if (abort && (state_q == BNC_DN || state_q == HOLD || state_q == BNC_UP)) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= 8'hA5;
            code_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (code_q)
            4'd1:  begin key_row = 2'd0; key_col = 2'd0; end
            4'd2:  begin key_row = 2'd0; key_col = 2'd1; end
            4'd3:  begin key_row = 2'd0; key_col = 2'd2; end
            4'd10: begin key_row = 2'd0; key_col = 2'd3; end
            4'd4:  begin key_row = 2'd1; key_col = 2'd0; end
            4'd5:  begin key_row = 2'd1; key_col = 2'd1; end
            4'd6:  begin key_row = 2'd1; key_col = 2'd2; end
            4'd11: begin key_row = 2'd1; key_col = 2'd3; end
            4'd7:  begin key_row = 2'd2; key_col = 2'd0; end
            4'd8:  begin key_row = 2'd2; key_col = 2'd1; end
            4'd9:  begin key_row = 2'd2; key_col = 2'd2; end
            4'd12: begin key_row = 2'd2; key_col = 2'd3; end
            4'd14: begin key_row = 2'd3; key_col = 2'd0; end
            4'd0:  begin key_row = 2'd3; key_col = 2'd1; end
            4'd15: begin key_row = 2'd3; key_col = 2'd2; end
            default: begin key_row = 2'd3; key_col = 2'd3; end
        endcase
    end

    assign contact   = (state_q == HOLD) |
                       (((state_q == BNC_DN) | (state_q == BNC_UP)) & lfsr_q[0]);
    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // row feeds column without a register, like the real passive switch matrix
    always_comb begin
        column = 4'b1111;
        if (contact && !row[key_row]) begin
            column[key_col] = 1'b0;
        end
    end

endmodule

// File: tb/tb_module_keypad_emulator.sv
// tb/tb_module_keypad_emulator.sv - bench for the keypad emulator (default and fast parameter sets)
module tb_module_keypad_emulator;

    logic       clk;
    logic       rst;
    logic       kv   [2];
    logic [3:0] kc   [2];
    logic       ab   [2];
    logic [3:0] rw   [2];
    logic       rdy  [2];
    logic [3:0] col  [2];
    logic       cont [2];
    logic       busy [2];
    logic       done [2];

    int checks = 0;
    int errors = 0;

    module_keypad_emulator #(.BOUNCE_CYCLES(5), .PRESS_CYCLES(200), .GAP_CYCLES(200)) u_dut0 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_code(kc[0]), .key_ready(rdy[0]),
        .abort(ab[0]), .row(rw[0]), .column(col[0]), .contact(cont[0]), .busy(busy[0]), .done(done[0])
    );

    module_keypad_emulator #(.BOUNCE_CYCLES(0), .PRESS_CYCLES(4), .GAP_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_code(kc[1]), .key_ready(rdy[1]),
        .abort(ab[1]), .row(rw[1]), .column(col[1]), .contact(cont[1]), .busy(busy[1]), .done(done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // key position per code, (row, column)
    int krow [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int kcol [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};

    function automatic int pb(int i); return (i == 0) ? 5 : 0;   endfunction
    function automatic int pp(int i); return (i == 0) ? 200 : 4; endfunction
    function automatic int pg(int i); return (i == 0) ? 200 : 2; endfunction

    // reference model: transaction timeline in absolute cycle numbers
    int         cyc = 0;
    bit         en = 0;
    bit         m_act [2];
    int         m_s   [2];
    int         m_g   [2];
    int         m_dn  [2];
    logic [3:0] m_code[2];
    logic [7:0] m_lf  [2];

    function automatic logic [7:0] lfsr_next(logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic e_busy(int i);
        return m_act[i] && (cyc < m_dn[i]);
    endfunction

    function automatic logic e_done(int i);
        return m_act[i] && (cyc == m_dn[i]);
    endfunction

    function automatic logic e_cont(int i);
        int k = cyc - m_s[i];
        if (!m_act[i] || cyc >= m_g[i]) return 1'b0;
        if (k < pb(i) || k >= pb(i) + pp(i)) return m_lf[i][0];
        return 1'b1;
    endfunction

    function automatic logic [3:0] e_col(int i);
        logic [3:0] c = 4'hF;
        if (e_cont(i) && !rw[i][krow[m_code[i]]]) c[kcol[m_code[i]]] = 1'b0;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i]  = 1'b0;
                m_lf[i]   = 8'hA5;
                m_code[i] = 4'd0;
            end else begin
                logic bz = e_busy(i);
                m_lf[i] = lfsr_next(m_lf[i]);
                if (!bz && kv[i]) begin
                    m_act[i]  = 1'b1;
                    m_s[i]    = cyc + 1;
                    m_g[i]    = cyc + 1 + 2 * pb(i) + pp(i);
                    m_dn[i]   = m_g[i] + pg(i);
                    m_code[i] = kc[i];
                end else if (ab[i] && bz && cyc < m_g[i]) begin
                    m_g[i]  = cyc + 1;
                    m_dn[i] = cyc + 1 + pg(i);
                end
            end
        end
        if (rst) en = 1'b1;
        cyc++;
    endtask

    // one clock cycle: compare on the falling edge, advance the model on the rising edge
    task automatic tick();
        @(negedge clk);
        if (en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("mon_busy%0d", i), busy[i], e_busy(i));
                check($sformatf("mon_ready%0d", i), rdy[i], !e_busy(i));
                check($sformatf("mon_done%0d", i), done[i], e_done(i));
                check($sformatf("mon_contact%0d", i), cont[i], e_cont(i));
                check($sformatf("mon_col%0d", i), col[i], e_col(i));
            end
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_txn(input int i, input int code, input logic [3:0] row,
                           input logic [3:0] hold_col, input string tag);
        int b = pb(i);
        int p = pp(i);
        int g = pg(i);
        int hc = 0;
        int cc = 0;
        int gc = 0;
        int lat = -1;
        rw[i] = row;
        kc[i] = code[3:0];
        kv[i] = 1'b1;
        tick();
        kv[i] = 1'b0;
        for (int k = 0; k < 2 * b + p + g + 20 && lat < 0; k++) begin
            #2;
            if (k >= b && k < b + p) begin
                if (col[i] == hold_col) hc++;
                if (cont[i]) cc++;
            end
            if (k >= 2 * b + p && k < 2 * b + p + g && !cont[i] && col[i] == 4'hF) gc++;
            if (done[i]) lat = k;
            tick();
        end
        check({tag, "_hold_col"}, hc, p);
        check({tag, "_hold_contact"}, cc, p);
        check({tag, "_gap_open"}, gc, g);
        check({tag, "_latency"}, lat, 2 * b + p + g);
    endtask

    typedef struct {
        int         code;
        logic [3:0] row;
        logic [3:0] col;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;
        int dcnt;
        vecs[0] = '{10, 4'b1110, 4'b0111};
        vecs[1] = '{15, 4'b0111, 4'b1011};
        vecs[2] = '{4,  4'b1101, 4'b1110};
        vecs[3] = '{4,  4'b1110, 4'b1111};
        vecs[4] = '{1,  4'b1101, 4'b1111};
        vecs[5] = '{0,  4'b0111, 4'b1101};
        vecs[6] = '{13, 4'b0000, 4'b0111};
        vecs[7] = '{9,  4'b1011, 4'b1011};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            kv[i] = 1'b0; kc[i] = 4'd0; ab[i] = 1'b0; rw[i] = 4'b0000;
        end
        repeat (3) tick();
        rst = 1'b0;
        #2;
        check("rst_col", col[0], 4'hF);
        check("rst_ready", rdy[0], 1'b1);
        check("rst_busy", busy[0], 1'b0);
        check("rst_done", done[0], 1'b0);

        run_txn(0, 1, 4'b1110, 4'b1110, "key1");

        for (int v = 0; v < 8; v++)
            run_txn(1, vecs[v].code, vecs[v].row, vecs[v].col, $sformatf("vec%0d", v));

        // back-to-back with key_valid held, then an ignored pulse while busy
        rw[1] = 4'b1101; kc[1] = 4'd2; kv[1] = 1'b1;
        tick();
        kc[1] = 4'd4;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            #2;
            if (done[1]) lat = k;
            tick();
        end
        check("b2b_first_latency", lat, 6);
        kv[1] = 1'b0;
        #2;
        check("b2b_second_busy", busy[1], 1'b1);
        check("b2b_key4_col", col[1], 4'b1110);
        tick();
        kv[1] = 1'b1; kc[1] = 4'd7;
        tick();
        kv[1] = 1'b0;
        #2;
        check("b2b_ignored_col", col[1], 4'b1110);
        lat = -1;
        for (int k = 2; k < 20 && lat < 0; k++) begin
            if (done[1]) lat = k;
            tick();
            #2;
        end
        check("b2b_second_latency", lat, 6);
        check("b2b_no_queue", busy[1], 1'b0);

        // abort in HOLD
        rw[0] = 4'b1101; kc[0] = 4'd5; kv[0] = 1'b1;
        tick();
        kv[0] = 1'b0;
        repeat (15) tick();
        ab[0] = 1'b1;
        #2;
        check("abort_hold_col", col[0], 4'b1101);
        tick();
        ab[0] = 1'b0;
        lat = -1;
        for (int k = 16; k < 300 && lat < 0; k++) begin
            #2;
            if (k == 16) begin
                check("abort_contact", cont[0], 1'b0);
                check("abort_busy", busy[0], 1'b1);
            end
            if (done[0]) lat = k;
            tick();
        end
        check("abort_latency", lat, 216);

        // reset in the middle of HOLD
        rw[0] = 4'b1110; kc[0] = 4'd3; kv[0] = 1'b1;
        tick();
        kv[0] = 1'b0;
        repeat (50) tick();
        #2;
        check("pre_rst_col", col[0], 4'b1011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        check("mid_rst_col", col[0], 4'hF);
        check("mid_rst_ready", rdy[0], 1'b1);
        check("mid_rst_contact", cont[0], 1'b0);
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (done[0]) dcnt++;
            tick();
            #2;
        end
        check("mid_rst_no_done", dcnt, 0);

        // random traffic on both instances against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                kv[i] = ($urandom_range(0, 3) == 0);
                kc[i] = 4'($urandom);
                ab[i] = ($urandom_range(0, (i == 0) ? 63 : 15) == 0);
                rw[i] = 4'($urandom);
            end
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            kv[i] = 1'b0; ab[i] = 1'b0;
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
